// File: rtl/prog_down_counter_if.sv
// Load/decrement control and status bundle for prog_down_counter.
interface prog_down_counter_if #(
  parameter int N      = 4,
  parameter int STEP_W = 4
);
  logic              load_valid;
  logic              load_ready;
  logic [N-1:0]      load_value;
  logic              en;
  logic [STEP_W-1:0] step;
  logic              mode;
  logic              auto_reload;
  logic              clr_flag;
  logic [N-1:0]      count;
  logic              zero;
  logic              tc_pulse;
  logic              underflow;
  logic              busy;

  modport master (
    output load_valid, load_value, en, step, mode, auto_reload, clr_flag,
    input  load_ready, count, zero, tc_pulse, underflow, busy
  );

  modport slave (
    input  load_valid, load_value, en, step, mode, auto_reload, clr_flag,
    output load_ready, count, zero, tc_pulse, underflow, busy
  );
endinterface

// File: rtl/prog_down_counter.sv
// Programmable-step down-counter with saturate / wrap / auto-reload terminal
// handling, a registered terminal-count pulse and a sticky underflow flag.
module prog_down_counter #(
  parameter int N      = 4,
  parameter int STEP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  prog_down_counter_if.slave  io
);

  generate
    if (STEP_W > N) begin : g_bad_step_w
      $error("prog_down_counter: STEP_W must not exceed N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic         uf_q, uf_d;

  logic [N:0]   diff;
  logic         borrow;
  logic         term;
  logic         load_fire;
  logic         dec_fire;

  // Extra top bit of the difference captures the borrow out of N bits.
  assign diff      = {1'b0, count_q} - {{(N + 1 - STEP_W){1'b0}}, io.step};
  assign borrow    = diff[N];
  assign term      = (diff[N-1:0] == '0) || borrow;
  assign load_fire = io.load_valid && (state_q != RUN);
  assign dec_fire  = (state_q == RUN) && io.en && (io.step != '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    uf_d     = uf_q && !io.clr_flag;
    if (load_fire) begin
      count_d  = io.load_value;
      reload_d = io.load_value;
      state_d  = RUN;
    end else if (dec_fire) begin
      if (!term) begin
        count_d = diff[N-1:0];
      end else begin
        tc_d = 1'b1;
        // Set beats a same-cycle clear.
        if (borrow) uf_d = 1'b1;
        if (io.auto_reload) begin
          count_d = reload_q;
        end else if (io.mode) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = diff[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      uf_q     <= uf_d;
    end
  end

  assign io.count      = count_q;
  assign io.zero       = (count_q == '0);
  assign io.tc_pulse   = tc_q;
  assign io.underflow  = uf_q;
  assign io.load_ready = (state_q != RUN);
  assign io.busy       = (state_q == RUN);

endmodule

// File: doc/prog_down_counter.md
Name: prog_down_counter

Overview:
Parametrised, clocked down-counter. It is the sequential successor to the combinational decrementor.
- Loads a start value through a valid/ready handshake.
- Decrements by a programmable step on each enabled cycle.
- Handles terminal count by saturate, wrap or auto-reload.
- Reports zero, a terminal-count pulse and a sticky underflow flag.
Used as the timer/loop-count primitive in the arithmetic library.

Parameters:
N, 4, counter width in bits (N >= 2)
STEP_W, 4, step input width; STEP_W <= N, enforced by elaboration-time check

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load request
load_ready  output  1  high when a load can be accepted
load_value  input  N  start value, captured on handshake
en  input  1  decrement enable
step  input  STEP_W  decrement amount, zero-extended to N; 0 = hold
mode  input  1  0 = WRAP, 1 = SAT
auto_reload  input  1  1 = reload start value at terminal count (overrides mode)
clr_flag  input  1  clears underflow
count  output  N  current count (registered)
zero  output  1  combinational, count == 0
tc_pulse  output  1  registered one-cycle terminal-count pulse
underflow  output  1  sticky borrow flag
busy  output  1  high in RUN

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low.
- Reset values: all registers clear immediately on rst_n low, also mid-count.
  - count=0, reload_reg=0, tc_pulse=0, underflow=0, state=IDLE.
  - Hence zero=1, load_ready=1, busy=0.
- States: IDLE, RUN, DONE.
  - load_ready=1 in IDLE and DONE, 0 in RUN.
  - busy=1 only in RUN.
- Load: accepted at the rising edge where load_valid && load_ready.
  - count <= load_value; reload_reg <= load_value; state <= RUN.
  - A load of 0 is legal and enters RUN with count=0.
  - load_valid in RUN is ignored, not queued.
- RUN, en=0 or step=0: hold count; tc_pulse=0.
- RUN, en=1, step!=0: compute d = {1'b0,count} - {0,step} in N+1 bits.
  - Borrow = d[N]. Terminal event = (d[N-1:0]==0) || borrow.
  - No event: count <= d[N-1:0].
  - Event with auto_reload=1: count <= reload_reg; stay RUN.
  - Event, auto_reload=0, SAT: count <= 0; state <= DONE.
  - Event, auto_reload=0, WRAP: count <= d[N-1:0] (modulo 2^N); stay RUN.
  - In every event case, tc_pulse=1 on the following cycle only.
  - In every event case with borrow, underflow is set.
  - Exact reach of 0 (no borrow) does not set underflow.
- Latency: count updates one cycle after the enabling edge; tc_pulse aligns with the count update.
- DONE: count held at 0, en ignored, waits for load. IDLE behaves identically.
- Underflow:
  - Cleared by clr_flag at the clock edge.
  - Simultaneous set and clear: set wins.
  - Not cleared by load.
- mode, auto_reload and step are sampled every cycle and may change while in RUN.
- Back-to-back: a load accepted in DONE on the same cycle that en=1 performs the load only; no decrement that cycle.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-RUN with count=9 -> count=0, tc_pulse=0, underflow=0, load_ready=1, busy=0 without waiting for a clock edge.
2. SAT, step=1, load 5, en=1 -> count 4,3,2,1,0 over five cycles.
   - tc_pulse=1 with count=0; then state DONE, load_ready=1.
   - underflow stays 0; further en keeps count 0.
3. WRAP, step=1, load 0, en=1 -> count=15, underflow=1, tc_pulse=1; stays RUN; next cycle count=14, tc_pulse=0.
4. auto_reload=1, step=2, load 3 -> count 1, then borrow -> count=3, tc_pulse=1, underflow=1; sequence 1,3,1,3 repeats.
5. Load 7; hold en=0 for 3 cycles -> count stays 7.
   - load_valid with load_value=2 during RUN -> ignored, count stays 7.
   - step=0 with en=1 -> holds 7.
6. Flags: with underflow=1, assert clr_flag on the same cycle as a new borrow -> underflow stays 1. clr_flag alone on the next cycle -> underflow=0.
